// File: rtl/rx_frame_sync_pkg.sv
// rx_frame_sync_pkg: shared states, SFD nibbles and CRC-16 constants for the receive deframer.
// Revision: 1.0
`default_nettype none

package rx_frame_sync_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        SFD_LO  = 3'd1,
        SFD_HI  = 3'd2,
        LEN_LO  = 3'd3,
        LEN_HI  = 3'd4,
        PAYLOAD = 3'd5
    } state_t;

    localparam logic [3:0]  SFD_LO_NIB = 4'h7;
    localparam logic [3:0]  SFD_HI_NIB = 4'hA;
    localparam logic [15:0] CRC_POLY   = 16'h8408;
    localparam logic [15:0] CRC_INIT   = 16'h0000;

    // Reflected CRC-16, one byte per call, data consumed LSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_frame_sync_if.sv
// rx_frame_sync_if: FIFO-read side and byte-stream side of the deframer.
// Revision: 1.0
`default_nettype none

interface rx_frame_sync_if;
    logic [3:0] inFifoData;
    logic       inFifoEmpty;
    logic       outFifoReadEnable;
    logic [7:0] outByte;
    logic       outByteValid;
    logic       inByteReady;
    logic       outSof;
    logic       outEof;
    logic [6:0] outLength;
    logic       outFrameError;
    logic       outFcsOk;

    modport master (
        input  inFifoData, inFifoEmpty, inByteReady,
        output outFifoReadEnable, outByte, outByteValid, outSof, outEof,
               outLength, outFrameError, outFcsOk
    );

    modport slave (
        output inFifoData, inFifoEmpty, inByteReady,
        input  outFifoReadEnable, outByte, outByteValid, outSof, outEof,
               outLength, outFrameError, outFcsOk
    );
endinterface

`default_nettype wire

// File: rtl/rx_frame_sync_crc16_byte.sv
// crc16_byte: bytewise reflected CRC-16 register with synchronous clear and enable.
// Revision: 1.0
`default_nettype none

module crc16_byte
    import rx_frame_sync_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_enable,
    input  wire logic [7:0]  i_data,
    output logic      [15:0] o_crc_next
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    assign o_crc_next = crc16_update(crc_q, i_data);

    always_comb begin
        crc_d = crc_q;
        if (i_clear)       crc_d = CRC_INIT;
        else if (i_enable) crc_d = o_crc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= CRC_INIT;
        else     crc_q <= crc_d;
    end

endmodule

`default_nettype wire

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: nibble-FIFO deframer (preamble/SFD hunt, PHR length, payload bytes).
// Optional CRC-16 FCS check when RX_FRAME_SYNC_FCS_EN is defined. Revision: 1.0
`default_nettype none

module rx_frame_sync
    import rx_frame_sync_pkg::*;
#(
    parameter int PREAMBLE_NIBBLES = 8,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int MAX_LENGTH       = 127
) (
    input  wire logic         inClock,
    input  wire logic         inReset,
    rx_frame_sync_if.master   bus
);

    localparam int                  c_IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          c_PRE       = 4'(PREAMBLE_NIBBLES);
    localparam logic [6:0]          c_MAX_LEN   = 7'(MAX_LENGTH);
`ifdef RX_FRAME_SYNC_FCS_EN
    localparam logic [6:0]          c_MIN_LEN   = 7'd3;
`else
    localparam logic [6:0]          c_MIN_LEN   = 7'd1;
`endif

    state_t              state_q,     state_d;
    logic                pending_q,   pending_d;
    logic [3:0]          zcnt_q,      zcnt_d;
    logic [3:0]          len_lo_q,    len_lo_d;
    logic [6:0]          length_q,    length_d;
    logic [6:0]          bytecnt_q,   bytecnt_d;
    logic                nib_odd_q,   nib_odd_d;
    logic [3:0]          lo_nib_q,    lo_nib_d;
    logic [c_IDLE_W-1:0] idle_q,      idle_d;
    logic                slot_full_q, slot_full_d;
    logic [7:0]          byte_q,      byte_d;
    logic                sof_q,       sof_d;
    logic                eof_q,       eof_d;
    logic                err_q,       err_d;

    logic       w_stall;
    logic       w_rd_en;
    logic       w_xfer;
    logic       w_timed;
    logic [3:0] w_nib;
    logic [3:0] w_zinc;
    logic [6:0] w_len;
    logic       w_len_ok;
    logic [7:0] w_byte_new;

    assign w_nib      = bus.inFifoData;
    assign w_stall    = (state_q == PAYLOAD) && slot_full_q && !bus.inByteReady;
    // Gated by reset so the strobe is low for as long as reset is held.
    assign w_rd_en    = !inReset && !bus.inFifoEmpty && !pending_q && !w_stall;
    assign w_xfer     = slot_full_q && bus.inByteReady;
    assign w_timed    = (state_q == SFD_HI) || (state_q == LEN_LO) ||
                        (state_q == LEN_HI) || (state_q == PAYLOAD);
    assign w_zinc     = (zcnt_q == c_PRE) ? zcnt_q : zcnt_q + 4'd1;
    assign w_len      = {w_nib[2:0], len_lo_q};
    assign w_len_ok   = (w_len >= c_MIN_LEN) && (w_len <= c_MAX_LEN);
    assign w_byte_new = {w_nib, lo_nib_q};

    always_comb begin
        state_d     = state_q;
        pending_d   = w_rd_en;
        zcnt_d      = zcnt_q;
        len_lo_d    = len_lo_q;
        length_d    = length_q;
        bytecnt_d   = bytecnt_q;
        nib_odd_d   = nib_odd_q;
        lo_nib_d    = lo_nib_q;
        idle_d      = idle_q;
        slot_full_d = slot_full_q;
        byte_d      = byte_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        err_d       = 1'b0;

        if (w_xfer) begin
            slot_full_d = 1'b0;
            sof_d       = 1'b0;
            eof_d       = 1'b0;
            if (eof_q) begin
                state_d = HUNT;
                zcnt_d  = '0;
                idle_d  = '0;
            end
        end

        // A sampled nibble wins over a timeout in the same cycle.
        if (pending_q) begin
            idle_d = '0;
            case (state_q)
                HUNT: begin
                    if (w_nib == 4'h0) begin
                        zcnt_d = w_zinc;
                        if (w_zinc == c_PRE) begin
                            state_d = SFD_LO;
                            zcnt_d  = '0;
                        end
                    end else begin
                        zcnt_d = '0;
                    end
                end
                SFD_LO: begin
                    if (w_nib == SFD_LO_NIB) begin
                        state_d = SFD_HI;
                    end else if (w_nib != 4'h0) begin
                        state_d = HUNT;
                        zcnt_d  = '0;
                    end
                end
                SFD_HI: begin
                    state_d = (w_nib == SFD_HI_NIB) ? LEN_LO : HUNT;
                    zcnt_d  = '0;
                end
                LEN_LO: begin
                    len_lo_d = w_nib;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    if (w_len_ok) begin
                        length_d  = w_len;
                        bytecnt_d = '0;
                        nib_odd_d = 1'b0;
                        state_d   = PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        zcnt_d  = '0;
                    end
                end
                PAYLOAD: begin
                    if (!nib_odd_q) begin
                        lo_nib_d  = w_nib;
                        nib_odd_d = 1'b1;
                    end else begin
                        nib_odd_d   = 1'b0;
                        slot_full_d = 1'b1;
                        byte_d      = w_byte_new;
                        sof_d       = (bytecnt_q == 7'd0);
                        eof_d       = (bytecnt_q == length_q - 7'd1);
                        bytecnt_d   = bytecnt_q + 7'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    zcnt_d  = '0;
                end
            endcase
        end else if (w_timed && !w_stall) begin
            if (idle_q == c_IDLE_LAST) begin
                err_d       = 1'b1;
                state_d     = HUNT;
                zcnt_d      = '0;
                idle_d      = '0;
                slot_full_d = 1'b0;
                sof_d       = 1'b0;
                eof_d       = 1'b0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state_q     <= HUNT;
            pending_q   <= 1'b0;
            zcnt_q      <= '0;
            len_lo_q    <= '0;
            length_q    <= '0;
            bytecnt_q   <= '0;
            nib_odd_q   <= 1'b0;
            lo_nib_q    <= '0;
            idle_q      <= '0;
            slot_full_q <= 1'b0;
            byte_q      <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zcnt_q      <= zcnt_d;
            len_lo_q    <= len_lo_d;
            length_q    <= length_d;
            bytecnt_q   <= bytecnt_d;
            nib_odd_q   <= nib_odd_d;
            lo_nib_q    <= lo_nib_d;
            idle_q      <= idle_d;
            slot_full_q <= slot_full_d;
            byte_q      <= byte_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
        end
    end

    assign bus.outFifoReadEnable = w_rd_en;
    assign bus.outByte           = byte_q;
    assign bus.outByteValid      = slot_full_q;
    assign bus.outSof            = sof_q;
    assign bus.outEof            = eof_q;
    assign bus.outLength         = length_q;
    assign bus.outFrameError     = err_q;

`ifdef RX_FRAME_SYNC_FCS_EN
    logic        w_crc_clear;
    logic        w_byte_load;
    logic [15:0] w_crc_next;
    logic        fcs_ok_q, fcs_ok_d;

    assign w_crc_clear = pending_q && (state_q == LEN_HI) && w_len_ok;
    assign w_byte_load = pending_q && (state_q == PAYLOAD) && nib_odd_q;

    crc16_byte u_crc (
        .clk        (inClock),
        .rst        (inReset),
        .i_clear    (w_crc_clear),
        .i_enable   (w_byte_load),
        .i_data     (w_byte_new),
        .o_crc_next (w_crc_next)
    );

    // Residue including this byte; only meaningful when it is the Eof byte.
    always_comb begin
        fcs_ok_d = fcs_ok_q;
        if (w_byte_load) fcs_ok_d = (w_crc_next == 16'h0000);
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) fcs_ok_q <= 1'b0;
        else         fcs_ok_q <= fcs_ok_d;
    end

    assign bus.outFcsOk = fcs_ok_q && eof_q;
`else
    assign bus.outFcsOk = eof_q;
`endif

endmodule

`default_nettype wire
